// File: rtl/and_gate_pipe.sv
// Elastic STAGES-deep pipeline computing AND/OR/XOR/NAND of two operands, with an all-zero flag and an occupancy count.
// Latency is STAGES cycles from accept to out_valid; in_ready follows out_ready combinationally, and bubbles collapse under a stall.
module and_gate_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_zero,
  output logic [2:0]       count
);

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] zro;
  logic [WIDTH-1:0]  dat     [STAGES];
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] src_vld;
  logic [STAGES-1:0] src_zro;
  logic [WIDTH-1:0]  src_dat [STAGES];
  logic [WIDTH-1:0]  res;
  logic              accept;
  logic              xfer;
  logic              chain;

  always_comb begin
    res = '0;
    case (op)
      2'b00:   res = a & b;
      2'b01:   res = a | b;
      2'b10:   res = a ^ b;
      default: res = ~(a & b);
    endcase
  end

  // A stage can load when any stage at or beyond it is empty, or the output drains.
  always_comb begin
    load  = '0;
    chain = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      chain   = chain | !vld[k];
      load[k] = chain;
    end
  end

  assign in_ready  = reset & load[0];
  assign accept    = in_valid & in_ready;
  assign xfer      = vld[STAGES-1] & out_ready;
  assign out_valid = vld[STAGES-1];
  assign y         = dat[STAGES-1];
  assign y_zero    = zro[STAGES-1];

  always_comb begin
    src_vld    = '0;
    src_zro    = '0;
    src_vld[0] = accept;
    src_zro[0] = (res == '0);
    src_dat[0] = res;
    for (int k = 1; k < STAGES; k++) begin
      src_vld[k] = vld[k-1];
      src_zro[k] = zro[k-1];
      src_dat[k] = dat[k-1];
    end
  end

  // Data registers update only with valid data, so an empty stage keeps its last value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld <= '0;
      zro <= '0;
      for (int k = 0; k < STAGES; k++) dat[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          vld[k] <= src_vld[k];
          if (src_vld[k]) begin
            dat[k] <= src_dat[k];
            zro[k] <= src_zro[k];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 3'd0;
    end else begin
      case ({accept, xfer})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_and_gate_pipe.sv
// Bench for and_gate_pipe (WIDTH=8, STAGES=2): directed steps plus random traffic against a queue-based reference.
module tb_and_gate_pipe;
  localparam int W = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         y_zero;
  logic [2:0]   count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [W-1:0] q_dat[$];
  int           q_acc[$];
  int           last_leave = 0;
  logic [W-1:0] last_y = '0;
  logic         last_z = 1'b0;
  logic [W-1:0] held_y;

  and_gate_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .reset(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .y_zero(y_zero), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_fn(input logic [W-1:0] x, input logic [W-1:0] z, input logic [1:0] f);
    case (f)
      2'd0:    return x & z;
      2'd1:    return x | z;
      2'd2:    return x ^ z;
      default: return ~(x & z);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit model_ov();
    int ready_at;
    if (q_dat.size() == 0) return 1'b0;
    ready_at = q_acc[0] + S - 1;
    if (last_leave > ready_at) ready_at = last_leave;
    return ready_at <= cyc;
  endfunction

  function automatic void model_clear();
    q_dat.delete();
    q_acc.delete();
    last_leave = 0;
    last_y = '0;
    last_z = 1'b0;
  endfunction

  // Called at a falling edge: drive, compare against the model, then advance one clock.
  task automatic step(input bit iv, input logic [W-1:0] ai, input logic [W-1:0] bi,
                      input logic [1:0] opi, input bit ordy);
    bit ov, ir, acc, xf;
    logic [W-1:0] ey;
    logic ez;
    in_valid = iv; a = ai; b = bi; op = opi; out_ready = ordy;
    #1;
    ov = model_ov();
    ir = (q_dat.size() < S) || ordy;
    ey = ov ? q_dat[0] : last_y;
    ez = ov ? (q_dat[0] == '0) : last_z;
    check("in_ready", 32'(in_ready), 32'(ir));
    check("out_valid", 32'(out_valid), 32'(ov));
    check("y", 32'(y), 32'(ey));
    check("y_zero", 32'(y_zero), 32'(ez));
    check("count", 32'(count), q_dat.size());
    acc = iv && ir;
    xf  = ordy && ov;
    @(posedge clk);
    cyc++;
    if (xf) begin
      last_y = q_dat.pop_front();
      last_z = (last_y == '0);
      void'(q_acc.pop_front());
      last_leave = cyc;
    end
    if (acc) begin
      q_dat.push_back(ref_fn(ai, bi, opi));
      q_acc.push_back(cyc);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; a = 8'hAA; b = 8'h55; op = 2'd1; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_y", 32'(y), 0);
    check("rst_y_zero", 32'(y_zero), 0);
    check("rst_count", 32'(count), 0);
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    check("rel_in_ready", 32'(in_ready), 1);
    @(negedge clk);

    // One function at a time, result visible two cycles after accept
    step(1, 8'hF0, 8'h3C, 2'd0, 1); step(0, 8'h00, 8'h00, 2'd0, 1); #1;
    check("fn_and", 32'(y), 32'h30);
    step(1, 8'hF0, 8'h3C, 2'd1, 1); step(0, 8'h00, 8'h00, 2'd0, 1); #1;
    check("fn_or", 32'(y), 32'hFC);
    step(1, 8'hF0, 8'h3C, 2'd2, 1); step(0, 8'h00, 8'h00, 2'd0, 1); #1;
    check("fn_xor", 32'(y), 32'hCC);
    step(1, 8'hF0, 8'h3C, 2'd3, 1); step(0, 8'h00, 8'h00, 2'd0, 1); #1;
    check("fn_nand", 32'(y), 32'hCF);
    step(1, 8'h0F, 8'hF0, 2'd0, 1); step(0, 8'h00, 8'h00, 2'd0, 1); #1;
    check("fn_zero_y", 32'(y), 32'h00);
    check("fn_zero_flag", 32'(y_zero), 1);
    repeat (2) step(0, 8'h00, 8'h00, 2'd0, 1);

    // Back-to-back throughput
    for (int i = 0; i < 16; i++)
      step(1, 8'(i * 17 + 3), 8'(8'hFF - i), 2'(i), 1);
    repeat (3) step(0, 8'h00, 8'h00, 2'd0, 1);

    // Backpressure: third offer refused, op changes on stalled cycles
    step(1, 8'h12, 8'h34, 2'd1, 0);
    step(1, 8'h56, 8'h78, 2'd2, 0);
    step(1, 8'h9A, 8'hBC, 2'd3, 0);
    #1;
    check("bp_count", 32'(count), 2);
    check("bp_in_ready", 32'(in_ready), 0);
    held_y = y;
    step(1, 8'h9A, 8'hBC, 2'd0, 0);
    step(1, 8'h9A, 8'hBC, 2'd2, 0);
    #1;
    check("bp_y_stable", 32'(y), 32'(held_y));
    // Full with out_ready high: accept and emit together
    step(1, 8'h9A, 8'hBC, 2'd3, 1);
    #1;
    check("full_count", 32'(count), 2);
    repeat (4) step(0, 8'h00, 8'h00, 2'd0, 1);

    // Reset with results in flight
    step(1, 8'hFF, 8'hFF, 2'd0, 0);
    step(1, 8'hFF, 8'h01, 2'd1, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_count", 32'(count), 0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step(0, 8'h00, 8'h00, 2'd0, 1);

    // Random traffic with random stalls
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
           2'($urandom_range(0, 3)), ($urandom_range(0, 2) != 0));
    repeat (4) step(0, 8'h00, 8'h00, 2'd0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/and_gate_pipe.md
# and_gate_pipe

Parametrised, pipelined successor to the single-bit registered AND cell. It computes a selectable bitwise logic function (AND, OR, XOR, NAND) over two WIDTH-bit operands. Results pass through a STAGES-deep elastic pipeline with valid/ready handshakes on both sides. It sits between a producer and a consumer that may each stall, and reports the number of results in flight.

## Interface
- WIDTH, 8, operand/result width in bits (1..64)
- STAGES, 2, pipeline depth in registers (1..4)
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-low; asserting (0) clears all state immediately, release is synchronous to clk
- in_valid  input  1  producer offers a, b, op this cycle
- in_ready  output  1  block accepts the offered operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  2  function: 00 AND, 01 OR, 10 XOR, 11 NAND
- out_valid  output  1  y/y_zero hold a valid result
- out_ready  input  1  consumer takes the result this cycle
- y  output  WIDTH  result, registered
- y_zero  output  1  1 when the result at y is all zeros, registered with y
- count  output  3  number of valid results held in the pipeline (0..STAGES), registered

## Operation
- Transfer in: in_valid & in_ready on a rising edge. Transfer out: out_valid & out_ready on a rising edge.
- Function is evaluated combinationally at accept from that cycle's a, b, op. It is captured into stage 0 together with y_zero = (result == 0). op is latched per transaction, so changing op later never alters in-flight results.
- Each stage k holds valid_k, data_k, zero_k. The last stage drives out_valid, y, y_zero.
- Stage k loads from stage k-1, or stage 0 from input, when stage k is empty or stage k advances this cycle. Stage k advances when stage k+1 loads; the last stage advances on out_ready.
- in_ready = !valid_0 | stage 0 advances. This allows full throughput of one transaction per cycle with out_ready held high. Bubbles collapse, so a gap in input does not persist if downstream stalls.
- A non-accepted input has no effect. a/b/op are don't-care when in_valid = 0.
- While out_valid & !out_ready, y and y_zero hold stable.
- count increments on accept only, decrements on output transfer only, and is unchanged on both together. It never exceeds STAGES.
- NAND: y = ~(a & b) over all WIDTH bits.
- No ordering change: results leave in acceptance order.

## Timing
- Reset values: out_valid 0, y 0, y_zero 0, count 0, all internal valid bits 0. in_ready reads 1 while reset is released and the pipeline is empty.
- While reset = 0, in_ready is forced 0 and no transfer occurs.
- Latency: a transaction accepted at edge N is at out_valid/y after edge N+STAGES-1, i.e. visible STAGES cycles after the accept cycle, given no stall.
- in_ready depends combinationally on out_ready (ready chain). No other combinational input-to-output path exists.
- Full: when all STAGES are valid and out_ready = 0, in_ready = 0. When all are valid and out_ready = 1, in_ready = 1 and accept/emit occur in the same cycle.
- Empty: out_valid = 0 and y holds its last value; no spurious transfer.
- Reset asserted mid-operation: all in-flight results are discarded at once, count goes to 0, and no partial result is emitted after release.
- STAGES = 1: a single register with in_ready = !out_valid | out_ready.

## Test plan
- Reset: hold reset 0 with in_valid 1 -> in_ready 0, out_valid 0, y 0, count 0; release -> in_ready 1.
- Functions at WIDTH=8, STAGES=2, out_ready 1, a=8'hF0, b=8'h3C -> successive results y=8'h30, 8'hFC, 8'hCC, 8'hCF for op 00..11, each 2 cycles after accept. a=8'h0F, b=8'hF0, op 00 -> y=8'h00, y_zero 1.
- Throughput: 16 back-to-back transactions with out_ready 1 -> one result per cycle in order, count steady at 2, in_ready never drops.
- Backpressure: out_ready 0 while feeding 3 transactions -> only 2 accepted, in_ready 0 thereafter, count 2, y stable. Raise out_ready -> both emitted in order, then the third accepted.
- Simultaneous accept/emit at full: out_ready 1 and in_valid 1 while count=2 -> count stays 2 and data order is preserved. Changing op on stalled cycles does not alter held results.
- Mid-flight reset: pulse reset low for one cycle with count=2 -> out_valid 0 and count 0 immediately; after release, the old results never appear.
